// File: rtl/demux4_stream_if.sv
// Stream bundle for the 4-way demux: one select-tagged input
// stream and four independent output streams.
interface demux4_stream_if #(
  parameter int W = 8
);
  logic                io_in_valid;
  logic                io_in_ready;
  logic [1:0]          io_in_sel;
  logic [W-1:0]        io_in_bits;
  logic [3:0]          io_out_valid;
  logic [3:0]          io_out_ready;
  logic [3:0][W-1:0]   io_out_bits;

  modport master (
    output io_in_valid,
    output io_in_sel,
    output io_in_bits,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_out_bits
  );

  modport slave (
    input  io_in_valid,
    input  io_in_sel,
    input  io_in_bits,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_out_bits
  );
endinterface

// File: rtl/demux4_stream.sv
// Four-way stream demultiplexer; each output owns a 2-entry FIFO
// so one stalled consumer only blocks beats addressed to it.
module demux4_stream #(
  parameter int W = 8
) (
  input logic           clock,
  input logic           reset_n,
  demux4_stream_if.slave io
);

  logic [1:0]   cnt [4];
  logic [3:0]   rp;
  logic [3:0]   wp;
  logic [3:0]   push;
  logic [3:0]   pop;
  logic [3:0]   vld;
  logic         rdy;
  logic [W-1:0] mem [4][2];

  // Ready looks only at the selected FIFO's fill, never at consumers.
  always_comb begin
    rdy = (cnt[io.io_in_sel] != 2'd2);
    for (int k = 0; k < 4; k++) begin
      vld[k]  = (cnt[k] != 2'd0);
      push[k] = io.io_in_valid & rdy
              & (io.io_in_sel == 2'(k));
      pop[k]  = vld[k] & io.io_out_ready[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      io.io_out_bits[k] = mem[k][rp[k]];
    end
  end

  assign io.io_in_ready  = rdy;
  assign io.io_out_valid = vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= 2'd0;
      end
      rp <= '0;
      wp <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) wp[k] <= ~wp[k];
        if (pop[k])  rp[k] <= ~rp[k];
        unique case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 2'd1;
          2'b01:   cnt[k] <= cnt[k] - 2'd1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  // Payload storage is not reset; valid gates its visibility.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (push[k]) mem[k][wp[k]] <= io.io_in_bits;
    end
  end

endmodule

// File: doc/demux4_stream.md
# demux4_stream

Four-way stream demultiplexer: the routing counterpart of the 2:1-tree multiplexer blocks. It accepts one valid/ready input stream carrying a 2-bit destination select and steers each beat to one of four output streams. Each output has its own 2-entry FIFO, so a stalled output never blocks traffic bound for the other three beyond one input beat. The block sits between a single producer and four independent consumers.

## Interface
- W, default 8: payload width in bits (1..64).
- clock, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset. Assertion clears state immediately. Release is synchronous to the design's clock domain.
- io_in_valid, input, 1: input beat present.
- io_in_ready, output, 1: block accepts the beat this cycle.
- io_in_sel, input, 2: destination index 0..3; sampled with io_in_bits.
- io_in_bits, input, W: payload.
- io_out_k_valid, output, 1, for k = 0..3: output k holds a beat.
- io_out_k_ready, input, 1, for k = 0..3: consumer k takes the head beat.
- io_out_k_bits, output, W, for k = 0..3: head payload of output k.

## Operation
- Per output k, keep a 2-entry FIFO:
  - storage mem_k[0..1] of W bits
  - 1-bit read pointer rp_k
  - 1-bit write pointer wp_k
  - 2-bit count cnt_k, range 0..2
- io_in_ready = (cnt[io_in_sel] != 2). It depends combinationally on io_in_sel only, never on any io_out_k_ready.
- push_k = io_in_valid & io_in_ready & (io_in_sel == k). At most one push_k is asserted per cycle.
- pop_k = io_out_k_valid & io_out_k_ready.
- io_out_k_valid = (cnt_k != 0).
- io_out_k_bits = mem_k[rp_k]. The bits are registered data and are held stable while valid is high and ready is low.
- On push_k: write mem_k[wp_k] with io_in_bits, and wp_k toggles.
- On pop_k: rp_k toggles.
- cnt_k update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop on the same k:
  - Allowed when cnt_k is 1.
  - Allowed when cnt_k is 0: the pop cannot occur because valid is 0, so this reduces to push only.
  - When cnt_k is 2, push is blocked, because ready is evaluated before the pop. There is no same-cycle pass-through when full.
- Ordering: beats to the same output leave in acceptance order. No ordering is guaranteed between different outputs.
- Handshake rules:
  - The producer must hold valid, sel and bits stable until the handshake completes.
  - The block does not assume this. Each cycle is evaluated independently.
- Reset:
  - All cnt_k, rp_k and wp_k clear to 0.
  - Every io_out_k_valid goes low immediately, asynchronously.
  - io_in_ready goes to 1 for every sel.
  - mem contents are don't-care and are not reset.
  - If reset arrives mid-operation, any beats in flight or queued are discarded without notification.

## Timing
- Latency: a beat accepted at rising edge N is visible as io_out_k_valid/bits after edge N (cycle N+1). There is no combinational input-to-output data path.
- Throughput:
  - One beat per cycle into any output whose consumer keeps ready high.
  - One beat per cycle overall when the destinations rotate.
- A full output with its consumer stalled blocks only beats targeting it. The producer may switch sel to another output in the next cycle.
- A full FIFO that is popped at edge N accepts a new push at edge N+1 at the earliest.
- Reset values: io_out_k_valid = 0 and io_in_ready = 1. io_out_k_bits is undefined until the first push.

## Test plan
- Routing:
  - Stimulus: after reset, all outputs ready=1; push 0x11 to sel 0, 0x22 to sel 1, 0x33 to sel 2, 0x44 to sel 3 on consecutive cycles.
  - Required: each io_out_k_valid pulses one cycle later with the matching byte; no cross-talk on the other outputs.
- Full/backpressure:
  - Stimulus: out_2 ready=0; push 0xA0, 0xA1, 0xA2 to sel 2.
  - Required: the first two are accepted and io_in_ready=0 on the third; with sel changed to 1, io_in_ready=1.
  - Stimulus: raise out_2 ready.
  - Required: 0xA0 then 0xA1 appear in order; 0xA2 is accepted one cycle after the first pop.
- Simultaneous push and pop:
  - Stimulus: cnt_3=1 (0x50 queued), out_3 ready=1; push 0x51 to sel 3 in the same cycle.
  - Required: cnt_3 stays 1, out bits go 0x50 then 0x51, no loss or duplication.
- Pointer wrap:
  - Stimulus: push 10 beats 0x00..0x09 to sel 0 while out_0 ready toggles every cycle.
  - Required: output sequence is exactly 0x00..0x09, and io_out_0_bits is stable whenever valid=1 and ready=0.
- Asynchronous reset mid-traffic:
  - Stimulus: with cnt_1=2 and cnt_2=1, assert reset_n=0 between clock edges.
  - Required: all valids drop without waiting for a clock edge and io_in_ready=1.
  - Required after release: the next push to sel 1 is delivered as the first beat.
- Randomized soak:
  - Stimulus: 10k cycles of random valid/sel/bits/ready.
  - Required: a scoreboard confirms per-output FIFO order, no drops, no duplicates, and cnt_k never exceeds 2.
